pot_cook_scheduler: RTL and testbench
=====================================

// Module: pot_cook_scheduler
// PURPOSE
//  Sequences cooking of the four stove pots (grid row 0, cols 8..11): counts cook and burn time per pot,
//  requests grid rewrites (RAW->COOKED, COOKED->FIRE) through a single shared write port.
//  Pending rewrites are arbitrated round-robin. Sits beside the player action logic, which owns object_grid.
//  Exports per-pot seconds remaining for the HUD.
// PARAMETERS
//  FRAMES_PER_SEC  60  ticks per second of game time
//  COOK_TIME       10  seconds RAW pot must sit on stove to become COOKED (1..15)
//  BURN_TIME       8   seconds a COOKED pot may sit before catching fire (1..15)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       reset, synchronous, active-high
//  tick       in   1       one-cycle pulse per video frame
//  game_state in   3       WELCOME=0 START=1 PLAY=2 PAUSE=3 FINISH=4
//  pot_cell   in   [3:0][3:0]  current grid object at stove slot i (slot i = col 8+i)
//  wr_ack     in   1       grid owner consumed the presented request this cycle
//  wr_req     out  1       write request valid
//  wr_slot    out  2       slot to rewrite
//  wr_obj     out  4       new object code
//  wr_expect  out  4       object owner must see in cell for write to apply (compare-and-swap)
//  time_left  out  [3:0][3:0]  seconds remaining per slot
//  fire_alarm out  1       OR of slots in FIRE
// BEHAVIOUR
//  Reset: all slots IDLE, counters 0, wr_req=0, wr_slot=0, wr_obj=0, wr_expect=0, time_left=0, fire_alarm=0, rr pointer=3.
//  Prescaler: counts tick 0..FRAMES_PER_SEC-1 only while game_state==PLAY; sec_pulse on wrap. PAUSE freezes it.
//  Slot FSM (per slot, one transition per clk max):
//   IDLE: pot_cell==G_POT_RAW && PLAY -> COOK, cnt=COOK_TIME.
//   COOK: pot_cell!=G_POT_RAW -> IDLE; else on sec_pulse cnt-1; cnt 1->0 on pulse -> COOK_REQ.
//   COOK_REQ: pending {obj=G_POT_COOKED, expect=G_POT_RAW}; on ack for this slot -> HOLD, cnt=BURN_TIME.
//   HOLD: pot_cell!=G_POT_COOKED -> IDLE; sec_pulse decrements; 1->0 -> FIRE_REQ.
//   FIRE_REQ: pending {obj=G_POT_FIRE, expect=G_POT_COOKED}; on ack -> FIRE.
//   FIRE: pot_cell!=G_POT_FIRE -> IDLE (extinguished/cleared).
//   REQ states not yet presented: cell != expect -> IDLE, request dropped.
//   Presented slot ignores cell check until ack; if owner rejected CAS, next-state check returns it to IDLE.
//  Game state: WELCOME/START/FINISH force every non-presented slot to IDLE, cnt=0; PAUSE holds all.
//  Arbiter: when wr_req==0, scan pending slots from ptr+1 upward mod 4; winner registered onto wr_* next cycle,
//   ptr<=winner. Outputs stable while wr_req=1. Cycle after ack: wr_req=0 (min 1 idle cycle), then re-arbitrate.
//   Latency slot->REQ to wr_req high: 1 cycle when port idle.
//  time_left: cnt in COOK/HOLD, else 0. fire_alarm registered, 1 cycle after FIRE entry.
//  Counters 4-bit; parameters >15 illegal (elaboration $error).
// CONFIGURATION
//  POT_BURN_EN defined: HOLD/FIRE_REQ/FIRE as above.
//  Undefined: COOK_REQ ack -> HOLD with no countdown (time_left=0), never FIRE_REQ; fire_alarm tied 0.
// STRUCTURE
//  overcooked_pkg: G_* object codes, game-state codes, slot_state_t enum, pot_req_t {obj, expect} struct.
//  Sub-module pot_slot_fsm (x4): slot FSM + counter, outputs pending/pot_req_t; arbiter + prescaler in top.
// TESTING
//  RAW in slot0, PLAY, FRAMES_PER_SEC=4 -> time_left[0] 10..1, wr_req slot0 obj=7 expect=6 after 40 ticks.
//  Ack held off 5 cycles -> wr_* stable 5 cycles; ack -> wr_req 0 next cycle, slot0 time_left=8.
//  Slots 1,2,3 finish same sec_pulse, ptr=3 -> grants 1,2,3 in order, ≥1 idle cycle between each.
//  Slot0 cell cleared to G_EMPTY mid-COOK (cnt=4) -> IDLE, time_left 0, no request ever issued.
//  PAUSE at cnt=6 for 100 ticks -> cnt stays 6; FINISH -> all time_left 0; reset mid-request -> wr_req 0 next clk.
//  POT_BURN_EN on: HOLD expires -> obj=8 expect=7, ack -> fire_alarm=1; cell->G_EMPTY -> alarm 0. Off: no FIRE request.

Source files
------------

// File: rtl/overcooked_pkg.sv
// rtl/overcooked_pkg.sv - shared codes and types for the stove pot scheduler (POT_BURN_EN selects burn/fire)
package overcooked_pkg;

    localparam logic [3:0] G_EMPTY      = 4'd0;
    localparam logic [3:0] G_POT_RAW    = 4'd6;
    localparam logic [3:0] G_POT_COOKED = 4'd7;
    localparam logic [3:0] G_POT_FIRE   = 4'd8;

    localparam logic [2:0] GS_WELCOME = 3'd0;
    localparam logic [2:0] GS_START   = 3'd1;
    localparam logic [2:0] GS_PLAY    = 3'd2;
    localparam logic [2:0] GS_PAUSE   = 3'd3;
    localparam logic [2:0] GS_FINISH  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COOK,
        S_COOK_REQ,
        S_HOLD,
        S_FIRE_REQ,
        S_FIRE
    } slot_state_t;

    typedef struct packed {
        logic [3:0] obj;
        logic [3:0] exp_obj;
    } pot_req_t;

`ifdef POT_BURN_EN
    localparam bit BURN_EN = 1'b1;
`else
    localparam bit BURN_EN = 1'b0;
`endif

endpackage

// File: rtl/pot_slot_fsm.sv
// rtl/pot_slot_fsm.sv - per-pot cook/burn state machine and seconds counter (POT_BURN_EN enables burn countdown)
module pot_slot_fsm
    import overcooked_pkg::*;
#(
    parameter int COOK_TIME = 10,
    parameter int BURN_TIME = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] game_state_i,
    input  logic [3:0] cell_i,
    input  logic       sec_pulse_i,
    input  logic       presented_i,
    input  logic       ack_i,
    output logic       pending_o,
    output pot_req_t   req_o,
    output logic [3:0] time_left_o,
    output logic       fire_o
);

    if (COOK_TIME < 1 || COOK_TIME > 15) begin : g_bad_cook
        $error("COOK_TIME must be 1..15");
    end
    if (BURN_TIME < 1 || BURN_TIME > 15) begin : g_bad_burn
        $error("BURN_TIME must be 1..15");
    end

    slot_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        play, pause;

    assign play  = (game_state_i == GS_PLAY);
    assign pause = (game_state_i == GS_PAUSE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ack_i) begin
            // The owner consumed our write; advance even if the game left PLAY meanwhile.
            if (state_q == S_COOK_REQ) begin
                state_d = S_HOLD;
`ifdef POT_BURN_EN
                cnt_d   = 4'(BURN_TIME);
`else
                cnt_d   = 4'd0;
`endif
            end else if (state_q == S_FIRE_REQ) begin
                state_d = S_FIRE;
                cnt_d   = 4'd0;
            end
        end else if (presented_i) begin
            state_d = state_q;
        end else if (play) begin
            unique case (state_q)
                S_IDLE: begin
                    if (cell_i == G_POT_RAW) begin
                        state_d = S_COOK;
                        cnt_d   = 4'(COOK_TIME);
                    end
                end
                S_COOK: begin
                    if (cell_i != G_POT_RAW) begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end else if (sec_pulse_i) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_d = S_COOK_REQ;
                    end
                end
                S_COOK_REQ: if (cell_i != G_POT_RAW) state_d = S_IDLE;
                S_HOLD: begin
                    if (cell_i != G_POT_COOKED) begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
`ifdef POT_BURN_EN
                    else if (sec_pulse_i) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_d = S_FIRE_REQ;
                    end
`endif
                end
                S_FIRE_REQ: if (cell_i != G_POT_COOKED) state_d = S_IDLE;
                S_FIRE:     if (cell_i != G_POT_FIRE) state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end else if (!pause) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end
    end

    assign pending_o   = (state_q == S_COOK_REQ) || (state_q == S_FIRE_REQ);
    assign req_o       = (state_q == S_FIRE_REQ) ? '{obj: G_POT_FIRE,   exp_obj: G_POT_COOKED}
                                                 : '{obj: G_POT_COOKED, exp_obj: G_POT_RAW};
    assign time_left_o = (state_q == S_COOK || state_q == S_HOLD) ? cnt_q : 4'd0;
    assign fire_o      = (state_q == S_FIRE);

endmodule

// File: rtl/pot_cook_scheduler.sv
// rtl/pot_cook_scheduler.sv - four stove pots, second prescaler and round-robin grid write arbiter (POT_BURN_EN)
module pot_cook_scheduler
    import overcooked_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COOK_TIME      = 10,
    parameter int BURN_TIME      = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic [2:0]      game_state,
    input  logic [3:0][3:0] pot_cell,
    input  logic            wr_ack,
    output logic            wr_req,
    output logic [1:0]      wr_slot,
    output logic [3:0]      wr_obj,
    output logic [3:0]      wr_expect,
    output logic [3:0][3:0] time_left,
    output logic            fire_alarm
);

    if (FRAMES_PER_SEC < 1 || FRAMES_PER_SEC > 65535) begin : g_bad_fps
        $error("FRAMES_PER_SEC must be 1..65535");
    end

    logic [15:0] pre_q, pre_d;
    logic        sec_pulse;
    logic        play;

    logic [3:0]  pending, slot_fire, presented, slot_ack;
    pot_req_t    slot_req [4];

    logic        grant_valid;
    logic [1:0]  grant_idx, scan_idx;
    logic [1:0]  ptr_q, ptr_d;
    logic        wr_req_q, wr_req_d;
    logic [1:0]  wr_slot_q, wr_slot_d;
    logic [3:0]  wr_obj_q, wr_obj_d, wr_exp_q, wr_exp_d;
    logic        fire_q, fire_d;

    assign play      = (game_state == GS_PLAY);
    assign sec_pulse = play && tick && (pre_q == 16'(FRAMES_PER_SEC - 1));

    always_comb begin
        pre_d = pre_q;
        if (play && tick) pre_d = sec_pulse ? 16'd0 : pre_q + 16'd1;
    end

    for (genvar i = 0; i < 4; i++) begin : g_slot
        // A slot being granted this cycle is already treated as presented so it cannot vanish under the grant.
        assign presented[i] = (wr_req_q && wr_slot_q == 2'(i)) || (grant_valid && grant_idx == 2'(i));
        assign slot_ack[i]  = wr_ack && wr_req_q && (wr_slot_q == 2'(i));

        pot_slot_fsm #(
            .COOK_TIME (COOK_TIME),
            .BURN_TIME (BURN_TIME)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .game_state_i (game_state),
            .cell_i       (pot_cell[i]),
            .sec_pulse_i  (sec_pulse),
            .presented_i  (presented[i]),
            .ack_i        (slot_ack[i]),
            .pending_o    (pending[i]),
            .req_o        (slot_req[i]),
            .time_left_o  (time_left[i]),
            .fire_o       (slot_fire[i])
        );
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        scan_idx    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!wr_req_q && !grant_valid && pending[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        wr_req_d  = wr_req_q;
        wr_slot_d = wr_slot_q;
        wr_obj_d  = wr_obj_q;
        wr_exp_d  = wr_exp_q;
        ptr_d     = ptr_q;
        if (wr_req_q) begin
            if (wr_ack) wr_req_d = 1'b0;
        end else if (grant_valid) begin
            wr_req_d  = 1'b1;
            wr_slot_d = grant_idx;
            wr_obj_d  = slot_req[grant_idx].obj;
            wr_exp_d  = slot_req[grant_idx].exp_obj;
            ptr_d     = grant_idx;
        end
        fire_d = BURN_EN & (|slot_fire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q     <= 16'd0;
            ptr_q     <= 2'd3;
            wr_req_q  <= 1'b0;
            wr_slot_q <= 2'd0;
            wr_obj_q  <= 4'd0;
            wr_exp_q  <= 4'd0;
            fire_q    <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            ptr_q     <= ptr_d;
            wr_req_q  <= wr_req_d;
            wr_slot_q <= wr_slot_d;
            wr_obj_q  <= wr_obj_d;
            wr_exp_q  <= wr_exp_d;
            fire_q    <= fire_d;
        end
    end

    assign wr_req     = wr_req_q;
    assign wr_slot    = wr_slot_q;
    assign wr_obj     = wr_obj_q;
    assign wr_expect  = wr_exp_q;
    assign fire_alarm = fire_q;

endmodule

// File: tb/tb_pot_cook_scheduler.sv
// tb/tb_pot_cook_scheduler.sv - scoreboard bench for pot_cook_scheduler (POT_BURN_EN selects fire checks)
module tb_pot_cook_scheduler;

    logic            clk;
    logic            reset;
    logic            tick;
    logic [2:0]      game_state;
    logic [3:0][3:0] pot_cell;
    logic            wr_ack;
    logic            wr_req;
    logic [1:0]      wr_slot;
    logic [3:0]      wr_obj;
    logic [3:0]      wr_expect;
    logic [3:0][3:0] time_left;
    logic            fire_alarm;

    pot_cook_scheduler #(
        .FRAMES_PER_SEC (4),
        .COOK_TIME      (10),
        .BURN_TIME      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .game_state (game_state),
        .pot_cell   (pot_cell),
        .wr_ack     (wr_ack),
        .wr_req     (wr_req),
        .wr_slot    (wr_slot),
        .wr_obj     (wr_obj),
        .wr_expect  (wr_expect),
        .time_left  (time_left),
        .fire_alarm (fire_alarm)
    );

    typedef struct {
        int slot;
        int obj;
        int exp_v;
    } req_t;

    req_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef POT_BURN_EN
    localparam int HOLD_LEFT = 8;
`else
    localparam int HOLD_LEFT = 0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic wait_req(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (wr_req) begin
                cycles = i;
                break;
            end
        end
        check("req_seen", int'(cycles != 0), 1);
    endtask

    task automatic push_req(input int s, input int o, input int e);
        req_t r;
        r.slot = s; r.obj = o; r.exp_v = e;
        exp_q.push_back(r);
    endtask

    // Monitor: pops one expectation per rising wr_req and checks it every cycle the request is held.
    initial begin
        bit   prev_req;
        bit   have_cur;
        req_t cur;
        prev_req = 1'b0;
        have_cur = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_req) begin
                if (!prev_req) begin
                    if (exp_q.size() == 0) begin
                        have_cur = 1'b0;
                        check("unexpected_req_slot", int'(wr_slot), -1);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                    end
                end
                if (have_cur) begin
                    check("wr_slot", int'(wr_slot), cur.slot);
                    check("wr_obj", int'(wr_obj), cur.obj);
                    check("wr_expect", int'(wr_expect), cur.exp_v);
                end
            end
            prev_req = wr_req;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        reset      = 1'b1;
        tick       = 1'b0;
        game_state = 3'd0;
        pot_cell   = '0;
        wr_ack     = 1'b0;
        step(3);
        check("rst_wr_req", int'(wr_req), 0);
        check("rst_wr_slot", int'(wr_slot), 0);
        check("rst_wr_obj", int'(wr_obj), 0);
        check("rst_wr_expect", int'(wr_expect), 0);
        check("rst_time_left", int'(time_left), 0);
        check("rst_fire_alarm", int'(fire_alarm), 0);
        reset = 1'b0;

        // Slot 0 cooks for 10 seconds at 4 ticks per second
        game_state  = 3'd2;
        pot_cell[0] = 4'd6;
        step(1);
        for (int s = 10; s >= 1; s--) begin
            check("cook_time_left0", int'(time_left[0]), s);
            if (s == 1) push_req(0, 7, 6);
            do_ticks(4);
        end
        check("cook_done_time_left0", int'(time_left[0]), 0);
        wait_req(cyc);
        check("req_latency0", cyc, 1);
        step(5);
        check("held_wr_req", int'(wr_req), 1);
        wr_ack = 1'b1;
        step(1);
        wr_ack = 1'b0;
        check("post_ack_wr_req", int'(wr_req), 0);
        check("hold_time_left0", int'(time_left[0]), HOLD_LEFT);
        pot_cell[0] = 4'd7;

`ifdef POT_BURN_EN
        push_req(0, 8, 7);
        do_ticks(32);
        wait_req(cyc);
        check("fire_req_latency", cyc, 1);
        wr_ack = 1'b1;
        step(1);
        wr_ack = 1'b0;
        pot_cell[0] = 4'd8;
        check("fire_alarm_early", int'(fire_alarm), 0);
        step(1);
        check("fire_alarm_on", int'(fire_alarm), 1);
        pot_cell[0] = 4'd0;
        step(2);
        check("fire_alarm_off", int'(fire_alarm), 0);
`else
        do_ticks(40);
        check("no_fire_wr_req", int'(wr_req), 0);
        check("no_fire_alarm", int'(fire_alarm), 0);
        check("no_fire_time_left0", int'(time_left[0]), 0);
        pot_cell[0] = 4'd0;
        step(2);
`endif

        // Three pots finish on the same second; pointer restarts at 3
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        pot_cell[1] = 4'd6;
        pot_cell[2] = 4'd6;
        pot_cell[3] = 4'd6;
        push_req(1, 7, 6);
        push_req(2, 7, 6);
        push_req(3, 7, 6);
        step(1);
        do_ticks(40);
        for (int s = 1; s <= 3; s++) begin
            wait_req(cyc);
            check("rr_latency", cyc, 1);
            wr_ack = 1'b1;
            step(1);
            wr_ack = 1'b0;
            check("rr_idle_gap", int'(wr_req), 0);
            pot_cell[s] = 4'd7;
        end
        step(1);
        check("rr_hold_time_left3", int'(time_left[3]), HOLD_LEFT);
        game_state = 3'd4;
        step(1);
        check("finish_time_left", int'(time_left), 0);
        pot_cell   = '0;
        game_state = 3'd2;
        step(2);

        // Pot removed mid-cook: back to idle, never requested
        pot_cell[0] = 4'd6;
        step(1);
        do_ticks(24);
        check("clear_cnt4", int'(time_left[0]), 4);
        pot_cell[0] = 4'd0;
        step(1);
        check("clear_time_left0", int'(time_left[0]), 0);
        do_ticks(40);
        check("clear_no_req", int'(wr_req), 0);

        // PAUSE freezes counter and prescaler
        pot_cell[0] = 4'd6;
        step(1);
        do_ticks(16);
        check("pause_cnt6_before", int'(time_left[0]), 6);
        game_state = 3'd3;
        do_ticks(100);
        check("pause_cnt6_after", int'(time_left[0]), 6);
        game_state = 3'd2;
        do_ticks(3);
        check("resume_cnt6", int'(time_left[0]), 6);
        do_ticks(1);
        check("resume_cnt5", int'(time_left[0]), 5);

        // Reset while a request is outstanding
        push_req(0, 7, 6);
        do_ticks(20);
        wait_req(cyc);
        check("req_latency_rst", cyc, 1);
        reset = 1'b1;
        step(1);
        check("rst_mid_wr_req", int'(wr_req), 0);
        check("rst_mid_time_left", int'(time_left), 0);
        reset = 1'b0;
        pot_cell = '0;
        step(3);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
